// File: rtl/inequality_tally.sv
`default_nettype none
// ============================================================================
//  Module   : inequality_tally
//  Brief    : Tallies one-hot compare codes from the inequality classifier.
//             Keeps saturating per-region hit counters, a malformed-code
//             error counter, and a run-length tracker that flags when the
//             same code has been seen STABLE_N times in a row.
//  Revision : 1.0  initial release
// ============================================================================
module inequality_tally #(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             stable,
  output logic [2:0]       stable_code
);

  localparam logic [CNT_W-1:0] c_max      = '1;
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero     = '0;
  localparam logic [CNT_W-1:0] c_stable_n = CNT_W'(STABLE_N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Counters hold at their maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_max) ? v : v + c_one;
  endfunction

  logic [CNT_W-1:0] r_cnt2, r_cnt1, r_cnt0, r_err;
  logic [CNT_W-1:0] r_run;
  logic [2:0]       r_code;
  logic             r_stable;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_run_nxt;
  logic [2:0]       w_code_nxt;

  logic w_accept;
  logic w_hit2, w_hit1, w_hit0, w_onehot;
  logic w_same;

  // Clear blocks acceptance so a colliding code is dropped, not counted.
  assign in_ready = ~clear;
  assign w_accept = in_valid & ~clear;

  assign w_hit2   = (in_code == 3'b100);
  assign w_hit1   = (in_code == 3'b010);
  assign w_hit0   = (in_code == 3'b001);
  assign w_onehot = w_hit2 | w_hit1 | w_hit0;
  // stable_code is 000 outside a run, so this never matches in IDLE.
  assign w_same   = (in_code == r_code);

  // Region hit and error counters, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt2 <= c_zero;
      r_cnt1 <= c_zero;
      r_cnt0 <= c_zero;
      r_err  <= c_zero;
    end else if (clear) begin
      r_cnt2 <= c_zero;
      r_cnt1 <= c_zero;
      r_cnt0 <= c_zero;
      r_err  <= c_zero;
    end else if (w_accept) begin
      if (w_hit2)    r_cnt2 <= sat_inc(r_cnt2);
      if (w_hit1)    r_cnt1 <= sat_inc(r_cnt1);
      if (w_hit0)    r_cnt0 <= sat_inc(r_cnt0);
      if (!w_onehot) r_err  <= sat_inc(r_err);
    end
  end

  // Tracker next-state: run length and current run code.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_code_nxt  = r_code;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_run_nxt   = c_zero;
      w_code_nxt  = 3'b000;
    end else if (w_accept) begin
      if (!w_onehot) begin
        w_state_nxt = ST_IDLE;
        w_run_nxt   = c_zero;
        w_code_nxt  = 3'b000;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt = ST_TRACK;
            w_run_nxt   = c_one;
            w_code_nxt  = in_code;
          end
          ST_TRACK: begin
            if (w_same) begin
              // STABLE_N never exceeds the counter maximum, so no overflow here.
              w_run_nxt = r_run + c_one;
              if ((r_run + c_one) >= c_stable_n) w_state_nxt = ST_LOCKED;
            end else begin
              w_run_nxt  = c_one;
              w_code_nxt = in_code;
            end
          end
          ST_LOCKED: begin
            if (w_same) begin
              w_run_nxt = sat_inc(r_run);
            end else begin
              w_state_nxt = ST_TRACK;
              w_run_nxt   = c_one;
              w_code_nxt  = in_code;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = c_zero;
            w_code_nxt  = 3'b000;
          end
        endcase
      end
    end
  end

  // Tracker state register; stable is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_run    <= c_zero;
      r_code   <= 3'b000;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_code   <= w_code_nxt;
      r_stable <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign cnt2        = r_cnt2;
  assign cnt1        = r_cnt1;
  assign cnt0        = r_cnt0;
  assign err_cnt     = r_err;
  assign run_len     = r_run;
  assign stable      = r_stable;
  assign stable_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_inequality_tally.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inequality_tally
//  Brief    : Self-checking bench for inequality_tally. Two instances share
//             inputs: an 8-bit-counter one and a 3-bit-counter one used for
//             saturation. Expected values come from an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inequality_tally;

  localparam int STABLE_N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] in_code = 3'b000;

  logic in_ready_a, stable_a;
  logic [7:0] cnt2_a, cnt1_a, cnt0_a, err_a, run_a;
  logic [2:0] code_a;

  logic in_ready_b, stable_b;
  logic [2:0] cnt2_b, cnt1_b, cnt0_b, err_b, run_b;
  logic [2:0] code_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inequality_tally #(.CNT_W(8), .STABLE_N(STABLE_N)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready_a), .cnt2(cnt2_a), .cnt1(cnt1_a), .cnt0(cnt0_a),
    .err_cnt(err_a), .run_len(run_a), .stable(stable_a), .stable_code(code_a)
  );

  inequality_tally #(.CNT_W(3), .STABLE_N(STABLE_N)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready_b), .cnt2(cnt2_b), .cnt1(cnt1_b), .cnt0(cnt0_b),
    .err_cnt(err_b), .run_len(run_b), .stable(stable_b), .stable_code(code_b)
  );

  logic [43:0] act_a;
  logic [18:0] act_b;
  assign act_a = {cnt2_a, cnt1_a, cnt0_a, err_a, run_a, stable_a, code_a};
  assign act_b = {cnt2_b, cnt1_b, cnt0_b, err_b, run_b, stable_b, code_b};

  // Reference model: plain integer counts per instance (0: 8-bit, 1: 3-bit).
  int m_c2[2], m_c1[2], m_c0[2], m_err[2], m_len[2];
  logic [2:0] m_code[2];
  int maxv[2] = '{255, 7};

  function automatic void model_zero();
    for (int i = 0; i < 2; i++) begin
      m_c2[i] = 0; m_c1[i] = 0; m_c0[i] = 0; m_err[i] = 0; m_len[i] = 0;
      m_code[i] = 3'b000;
    end
  endfunction

  function automatic int inc_sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // One clock edge of the reference: reset > clear > accept.
  function automatic void model_step(input logic rn, input logic clr,
                                     input logic v, input logic [2:0] c);
    if (!rn || clr) begin
      model_zero();
      return;
    end
    if (!v) return;
    for (int i = 0; i < 2; i++) begin
      if (c == 3'b100 || c == 3'b010 || c == 3'b001) begin
        if (c == 3'b100) m_c2[i] = inc_sat(m_c2[i], maxv[i]);
        if (c == 3'b010) m_c1[i] = inc_sat(m_c1[i], maxv[i]);
        if (c == 3'b001) m_c0[i] = inc_sat(m_c0[i], maxv[i]);
        if (m_len[i] > 0 && c == m_code[i]) m_len[i] = inc_sat(m_len[i], maxv[i]);
        else begin
          m_len[i] = 1;
          m_code[i] = c;
        end
      end else begin
        m_err[i] = inc_sat(m_err[i], maxv[i]);
        m_len[i] = 0;
        m_code[i] = 3'b000;
      end
    end
  endfunction

  function automatic logic [43:0] exp_a();
    return {8'(m_c2[0]), 8'(m_c1[0]), 8'(m_c0[0]), 8'(m_err[0]), 8'(m_len[0]),
            (m_len[0] >= STABLE_N), m_code[0]};
  endfunction

  function automatic logic [18:0] exp_b();
    return {3'(m_c2[1]), 3'(m_c1[1]), 3'(m_c0[1]), 3'(m_err[1]), 3'(m_len[1]),
            (m_len[1] >= STABLE_N), m_code[1]};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic cycle(input logic v, input logic [2:0] c, input logic clr);
    in_valid = v;
    in_code  = c;
    clear    = clr;
    @(posedge clk);
    model_step(rst_n, clr, v, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) cycle(1'b1, 3'b010, 1'b0);
    tests++;
    if (act_a !== 44'h0) begin
      fails++; $display("FAIL reset_state: dut=%h exp=%h", act_a, 44'h0);
    end
    tests++;
    if (in_ready_a !== 1'b1) begin
      fails++; $display("FAIL reset_ready: dut=%b exp=1", in_ready_a);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 3'b010, 1'b0);
      tests++;
      if (act_a !== exp_a()) begin
        fails++; $display("FAIL reset_hold: dut=%h exp=%h", act_a, exp_a());
      end
    end
  endtask

  task automatic test_lock();
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 3'b010, 1'b0);
      tests++;
      if (act_a !== exp_a() || cnt1_a !== 8'(k) || run_a !== 8'(k)) begin
        fails++; $display("FAIL lock_step%0d: dut=%h exp=%h", k, act_a, exp_a());
      end
    end
    tests++;
    if (stable_a !== 1'b1 || code_a !== 3'b010) begin
      fails++; $display("FAIL lock_stable: dut=%b/%b exp=1/010", stable_a, code_a);
    end
    cycle(1'b1, 3'b001, 1'b0);
    tests++;
    if (stable_a !== 1'b0 || run_a !== 8'd1 || cnt0_a !== 8'd1 || act_a !== exp_a()) begin
      fails++; $display("FAIL lock_break: dut=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_invalid();
    logic [7:0] c2_before;
    cycle(1'b0, 3'b000, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 3'b100, 1'b0);
    tests++;
    if (stable_a !== 1'b1) begin
      fails++; $display("FAIL inv_prelock: dut=%b exp=1", stable_a);
    end
    c2_before = cnt2_a;
    cycle(1'b1, 3'b110, 1'b0);
    tests++;
    if (err_a !== 8'd1 || run_a !== 8'd0 || code_a !== 3'b000 || stable_a !== 1'b0 ||
        cnt2_a !== c2_before || act_a !== exp_a()) begin
      fails++; $display("FAIL inv_110: dut=%h exp=%h", act_a, exp_a());
    end
    cycle(1'b1, 3'b000, 1'b0);
    tests++;
    if (err_a !== 8'd2 || act_a !== exp_a()) begin
      fails++; $display("FAIL inv_000: dut=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 3'b010, 1'b0);
    in_valid = 1'b1;
    in_code  = 3'b010;
    clear    = 1'b1;
    #1;
    tests++;
    if (in_ready_a !== 1'b0) begin
      fails++; $display("FAIL clear_ready: dut=%b exp=0", in_ready_a);
    end
    @(posedge clk);
    model_step(rst_n, 1'b1, 1'b1, 3'b010);
    #1;
    tests++;
    if (act_a !== 44'h0 || act_a !== exp_a()) begin
      fails++; $display("FAIL clear_zero: dut=%h exp=%h", act_a, 44'h0);
    end
    cycle(1'b1, 3'b010, 1'b0);
    tests++;
    if (cnt1_a !== 8'd1 || run_a !== 8'd1 || act_a !== exp_a()) begin
      fails++; $display("FAIL clear_next: dut=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 3'b000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 3'b001, 1'b0);
      tests++;
      if (act_b !== exp_b()) begin
        fails++; $display("FAIL sat_step%0d: dut=%h exp=%h", k, act_b, exp_b());
      end
    end
    tests++;
    if (cnt0_b !== 3'd7 || run_b !== 3'd7 || stable_b !== 1'b1 ||
        cnt1_b !== 3'd0 || cnt2_b !== 3'd0 || err_b !== 3'd0) begin
      fails++; $display("FAIL sat_final: dut=%h exp=cnt0=7 run=7 stable=1", act_b);
    end
    tests++;
    if (cnt0_a !== 8'd10 || run_a !== 8'd10) begin
      fails++; $display("FAIL sat_wide: dut=%0d/%0d exp=10/10", cnt0_a, run_a);
    end
  endtask

  task automatic test_idle_gaps();
    cycle(1'b0, 3'b000, 1'b1);
    cycle(1'b1, 3'b100, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'b011, 1'b0);
    tests++;
    if (run_a !== 8'd1 || act_a !== exp_a()) begin
      fails++; $display("FAIL gap_hold: dut=%h exp=%h", act_a, exp_a());
    end
    for (int k = 0; k < 3; k++) cycle(1'b1, 3'b100, 1'b0);
    tests++;
    if (run_a !== 8'd4 || stable_a !== 1'b1 || act_a !== exp_a()) begin
      fails++; $display("FAIL gap_lock: dut=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic v, clr;
    c = 3'b001;
    for (int k = 0; k < 400; k++) begin
      clr = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: c = c;
        3:       c = 3'b001 << $urandom_range(0, 2);
        4:       c = 3'b001 << $urandom_range(0, 2);
        default: c = 3'($urandom_range(0, 7));
      endcase
      cycle(v, c, clr);
      tests++;
      if (act_a !== exp_a() || act_b !== exp_b()) begin
        fails++;
        $display("FAIL random%0d: dut=%h/%h exp=%h/%h", k, act_a, act_b, exp_a(), exp_b());
      end
    end
  endtask

  initial begin
    model_zero();
    test_reset();
    test_lock();
    test_invalid();
    test_clear();
    test_saturation();
    test_idle_gaps();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/inequality_tally.md
# inequality_tally

Downstream consumer of the 4-bit inequality classifier's 3-bit one-hot compare code. It accepts one code per valid/ready handshake and keeps saturating per-region hit counters and an error counter for malformed (non-one-hot) codes. A run-length tracker asserts `stable` once the same code has been accepted `STABLE_N` times in a row. The block sits between the classifier and the status/readout logic; it is purely synchronous with one clock.

## Interface
- `CNT_W`, 8, width of each hit/error counter (≥2)
- `STABLE_N`, 4, consecutive identical valid codes required to assert `stable` (2..2^CNT_W-1)
- `clk`  input  1  sole clock, rising-edge
- `rst_n`  input  1  synchronous, active-low reset
- `clear`  input  1  synchronous counter/tracker clear, active-high
- `in_valid`  input  1  `in_code` is presented this cycle
- `in_code`  input  3  compare code from classifier; bit2/bit1/bit0 = region flags
- `in_ready`  output  1  block can accept; combinationally `~clear`
- `cnt2`, `cnt1`, `cnt0`  output  CNT_W each  accepted codes 100 / 010 / 001
- `err_cnt`  output  CNT_W  accepted codes that are not one-hot
- `run_len`  output  CNT_W  length of the current run of identical valid codes
- `stable`  output  1  run_len ≥ STABLE_N
- `stable_code`  output  3  code of the current run; 000 when no run

## Operation
- Accept = `in_valid & in_ready`. No accept → all state holds.
- Valid code = exactly one bit set (100, 010, 001). Invalid = 000, 011, 101, 110, 111.
- Accepted valid code: increment matching `cntX`, saturating at 2^CNT_W−1.
- Accepted invalid code: increment `err_cnt` (saturating), and force the tracker to IDLE.
- Tracker FSM, states IDLE / TRACK / LOCKED:
  - IDLE: `run_len`=0, `stable_code`=000, `stable`=0. Valid accept → TRACK, `run_len`=1, `stable_code`=code.
  - TRACK: same code → `run_len`+1; when the new value reaches STABLE_N → LOCKED. Different valid code → stay TRACK, `run_len`=1, `stable_code`=new code. Invalid code → IDLE.
  - LOCKED: `stable`=1. Same code → `run_len`+1, saturating; state stays LOCKED. Different valid code → TRACK, `run_len`=1. Invalid code → IDLE.
- `stable` is decoded as (state == LOCKED) and is registered-equivalent: it has no combinational path from inputs.
- `clear`: zeroes all counters and `run_len`, and puts the tracker in IDLE. `in_ready`=0 during clear, so a simultaneous `in_valid` is dropped and not counted.
- Priority: `rst_n`=0 > `clear` > accept.

## Timing
- Reset (`rst_n` low at a rising edge): all counters 0, `run_len` 0, `stable` 0, `stable_code` 000, state IDLE. `in_ready` follows `~clear` even during reset.
- Latency: an accept at edge N is reflected in all outputs immediately after edge N (one-cycle register latency). Back-to-back accepts every cycle are supported with no bubbles.
- `stable` rises right after the edge that accepts the STABLE_N-th identical code. It falls right after the edge that accepts a differing or invalid code.
- Saturation: a counter at its maximum stays at the maximum. It never wraps, and other counters are unaffected.
- Reset or clear mid-run: all state is lost, and the next valid accept starts a run at 1.
- All outputs are register-driven except `in_ready`.

## Test plan
- Reset, then check outputs: `rst_n`=0 for 2 cycles with `in_valid`=1 and code 010 → all counters 0, `stable`=0, `stable_code`=000. After release with `in_valid`=0, the outputs hold.
- Lock on one code (STABLE_N=4): accept 010 four times back-to-back.
  - `cnt1`=1,2,3,4 and `run_len`=1..4.
  - `stable`=1 after the 4th edge, with `stable_code`=010.
  - A 5th accept of 001 → `stable`=0, `run_len`=1, `cnt0`=1.
- Invalid code: from LOCKED on 100, accept 110 → `err_cnt`=1, state IDLE, `run_len`=0, `stable_code`=000, `cnt2` unchanged. Then accept 000 → `err_cnt`=2.
- Clear collision: `clear`=1 together with `in_valid`=1 and code 010 → `in_ready`=0, all counters 0 after the edge, `cnt1` stays 0. The next accept of 010 → `cnt1`=1, `run_len`=1.
- Saturation (CNT_W=3): accept 001 ten times → `cnt0`=7, `run_len`=7, `stable`=1, other counters 0.
- Idle gaps: accept 100, wait 3 cycles with `in_valid`=0, then accept 100 three more times (STABLE_N=4) → `run_len`=4, `stable`=1. Gaps do not break a run.
